// File: rtl/button_debounce_repeat.sv
// Debounced button with press/release/auto-repeat pulses; press_pulse lands STABLE_TICKS+1 edges after the raw press.
// No backpressure: all outputs are registered one-cycle strobes or levels, sampled on clock_divider_out.
module button_debounce_repeat #(
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clock_divider_out,
  input  logic reset,
  input  logic button_raw,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic count_pulse,
  output logic long_press
);

  localparam logic        IDLE_LVL   = ACTIVE_LOW;
  localparam logic [15:0] ST_LIM     = 16'(STABLE_TICKS);
  localparam logic [15:0] FIRST_LIM  = 16'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [15:0] RATE_LIM   = 16'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHECK,
    PRESSED,
    RELEASE_CHECK
  } state_t;

  state_t      state;
  logic        sync_1, sync_2;
  logic        btn_s;
  logic [15:0] stable_cnt;
  logic [15:0] stable_inc;
  logic [15:0] repeat_cnt;
  logic [15:0] repeat_lim;
  logic        press_ok;
  logic        rel_ok;

  always_ff @(posedge clock_divider_out or posedge reset) begin
    if (reset) begin
      sync_1 <= IDLE_LVL;
      sync_2 <= IDLE_LVL;
    end else begin
      sync_1 <= button_raw;
      sync_2 <= sync_1;
    end
  end

  assign btn_s      = sync_2 ^ ACTIVE_LOW;
  assign stable_inc = stable_cnt + 16'd1;
  // long_press doubles as the "first repeat already fired" flag
  assign repeat_lim = long_press ? RATE_LIM : FIRST_LIM;

  assign press_ok = btn_s &&
                    (((state == RELEASED) && (STABLE_TICKS == 1)) ||
                     ((state == PRESS_CHECK) && (stable_inc == ST_LIM)));
  assign rel_ok   = !btn_s &&
                    (((state == PRESSED) && (STABLE_TICKS == 1)) ||
                     ((state == RELEASE_CHECK) && (stable_inc == ST_LIM)));

  always_ff @(posedge clock_divider_out or posedge reset) begin
    if (reset) begin
      state         <= RELEASED;
      stable_cnt    <= 16'd0;
      repeat_cnt    <= 16'd0;
      button_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      count_pulse   <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      count_pulse   <= 1'b0;
      if (press_ok) begin
        state        <= PRESSED;
        button_level <= 1'b1;
        press_pulse  <= 1'b1;
        count_pulse  <= 1'b1;
        repeat_cnt   <= 16'd0;
        stable_cnt   <= 16'd0;
      end else if (rel_ok) begin
        state         <= RELEASED;
        button_level  <= 1'b0;
        long_press    <= 1'b0;
        release_pulse <= 1'b1;
        repeat_cnt    <= 16'd0;
        stable_cnt    <= 16'd0;
      end else begin
        case (state)
          RELEASED: begin
            if (btn_s) begin
              state      <= PRESS_CHECK;
              stable_cnt <= 16'd1;
            end
          end
          PRESS_CHECK: begin
            if (!btn_s) begin
              state      <= RELEASED;
              stable_cnt <= 16'd0;
            end else begin
              stable_cnt <= stable_inc;
            end
          end
          PRESSED: begin
            if (!btn_s) begin
              state      <= RELEASE_CHECK;
              stable_cnt <= 16'd1;
            end else if (REPEAT_DELAY > 0) begin
              if (repeat_cnt == repeat_lim) begin
                repeat_pulse <= 1'b1;
                count_pulse  <= 1'b1;
                long_press   <= 1'b1;
                repeat_cnt   <= 16'd0;
              end else begin
                repeat_cnt <= repeat_cnt + 16'd1;
              end
            end
          end
          RELEASE_CHECK: begin
            // a bounce back to pressed keeps repeat_cnt so the cadence just pauses
            if (btn_s) begin
              state      <= PRESSED;
              stable_cnt <= 16'd0;
            end else begin
              stable_cnt <= stable_inc;
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Bench for button_debounce_repeat: four parameterisations checked every edge against a
// run-length reference model, plus a vector table and hand sequences for the corner cases.
module tb_button_debounce_repeat;

  logic clk = 1'b0;
  logic reset;
  logic raw;
  logic raw_c;
  logic [3:0] lvl, pp, rp, rpt, cp, lp;

  always #5 clk = ~clk;

  localparam int P_ST [4] = '{4, 4, 4, 1};
  localparam int P_RD [4] = '{10, 0, 10, 2};
  localparam int P_RR [4] = '{3, 3, 3, 1};
  localparam bit P_AL [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  button_debounce_repeat #(.STABLE_TICKS(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .ACTIVE_LOW(1'b1)) dut_a (
    .clock_divider_out(clk), .reset(reset), .button_raw(raw),
    .button_level(lvl[0]), .press_pulse(pp[0]), .release_pulse(rp[0]),
    .repeat_pulse(rpt[0]), .count_pulse(cp[0]), .long_press(lp[0]));
  button_debounce_repeat #(.STABLE_TICKS(4), .REPEAT_DELAY(0), .REPEAT_RATE(3), .ACTIVE_LOW(1'b1)) dut_b (
    .clock_divider_out(clk), .reset(reset), .button_raw(raw),
    .button_level(lvl[1]), .press_pulse(pp[1]), .release_pulse(rp[1]),
    .repeat_pulse(rpt[1]), .count_pulse(cp[1]), .long_press(lp[1]));
  button_debounce_repeat #(.STABLE_TICKS(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .ACTIVE_LOW(1'b0)) dut_c (
    .clock_divider_out(clk), .reset(reset), .button_raw(raw_c),
    .button_level(lvl[2]), .press_pulse(pp[2]), .release_pulse(rp[2]),
    .repeat_pulse(rpt[2]), .count_pulse(cp[2]), .long_press(lp[2]));
  button_debounce_repeat #(.STABLE_TICKS(1), .REPEAT_DELAY(2), .REPEAT_RATE(1), .ACTIVE_LOW(1'b1)) dut_d (
    .clock_divider_out(clk), .reset(reset), .button_raw(raw),
    .button_level(lvl[3]), .press_pulse(pp[3]), .release_pulse(rp[3]),
    .repeat_pulse(rpt[3]), .count_pulse(cp[3]), .long_press(lp[3]));

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outv(input int i);
    return {lvl[i], pp[i], rp[i], rpt[i], cp[i], lp[i]};
  endfunction

  // Reference: level plus a run length of contrary samples, and ticks held since press/last repeat.
  typedef struct {
    bit s1, s2, level, lng, prs, rel, rpt;
    int run, hold;
  } mst_t;
  mst_t m [4];

  function automatic mst_t mreset(input bit al);
    mst_t r;
    r.s1 = al; r.s2 = al; r.level = 0; r.lng = 0;
    r.prs = 0; r.rel = 0; r.rpt = 0; r.run = 0; r.hold = 0;
    return r;
  endfunction

  function automatic mst_t mstep(input mst_t mi, input bit rawv, input int st, input int rd,
                                 input int rr, input bit al);
    mst_t r;
    bit s;
    int tgt;
    r = mi;
    s = al ? !r.s2 : r.s2;
    r.s2 = r.s1; r.s1 = rawv;
    r.prs = 0; r.rel = 0; r.rpt = 0;
    if (!r.level) begin
      if (s) begin
        r.run++;
        if (r.run == st) begin r.level = 1; r.prs = 1; r.run = 0; r.hold = 0; end
      end else r.run = 0;
    end else if (!s) begin
      r.run++;
      if (r.run == st) begin r.level = 0; r.lng = 0; r.rel = 1; r.run = 0; r.hold = 0; end
    end else if (r.run > 0) begin
      r.run = 0;
    end else if (rd > 0) begin
      tgt = r.lng ? rr : rd;
      r.hold++;
      if (r.hold == tgt) begin r.rpt = 1; r.lng = 1; r.hold = 0; end
    end
    return r;
  endfunction

  function automatic logic [5:0] mexp(input mst_t r);
    return {r.level, r.prs, r.rel, r.rpt, r.prs | r.rpt, r.lng};
  endfunction

  always begin
    @(posedge clk or posedge reset);
    for (int i = 0; i < 4; i++) begin
      if (reset) m[i] = mreset(P_AL[i]);
      else m[i] = mstep(m[i], (i == 2) ? raw_c : raw, P_ST[i], P_RD[i], P_RR[i], P_AL[i]);
    end
    #1;
    if (mon_en)
      for (int i = 0; i < 4; i++) chk($sformatf("model_dut%0d", i), 32'(outv(i)), 32'(mexp(m[i])));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    raw = 1'b1; raw_c = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  typedef struct {
    int         e;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl [13];

  initial begin
    int cnt, cnt_c, first, bad, np, nr, nl, dn_a, dn_c;
    // {level, press, release, repeat, count, long} of dut_a after edge e
    tbl[0]  = '{4,  6'b000000};
    tbl[1]  = '{5,  6'b110010};
    tbl[2]  = '{6,  6'b100000};
    tbl[3]  = '{14, 6'b100000};
    tbl[4]  = '{15, 6'b100111};
    tbl[5]  = '{16, 6'b100001};
    tbl[6]  = '{18, 6'b100111};
    tbl[7]  = '{21, 6'b100111};
    tbl[8]  = '{24, 6'b100111};
    tbl[9]  = '{25, 6'b100001};
    tbl[10] = '{29, 6'b100001};
    tbl[11] = '{30, 6'b001000};
    tbl[12] = '{31, 6'b000000};

    reset = 1'b1; raw = 1'b1; raw_c = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("reset_dut%0d", i), 32'(outv(i)), 32'd0);
    #2 reset = 1'b0;
    mon_en = 1'b1;
    idle(5);

    // clean press
    raw = 1'b0; cnt = 0; cnt_c = 0;
    for (int e = 0; e < 36; e++) begin
      tick();
      cnt += int'(cp[0]);
      cnt_c += int'(pp[2]);
      for (int k = 0; k < 13; k++)
        if (tbl[k].e == e) chk($sformatf("clean_E%0d", e), 32'(outv(0)), 32'(tbl[k].exp));
      raw = (e + 1 < 25) ? 1'b0 : 1'b1;
    end
    chk("clean_count_total", cnt, 5);
    chk("active_high_idle_no_press", cnt_c, 0);
    idle(10);

    // press bounce
    raw = 1'b0; bad = 0;
    for (int e = 0; e < 15; e++) begin
      tick();
      bad |= int'(lvl[0] | pp[0] | rp[0] | rpt[0]);
      raw = (e + 1 < 2) ? 1'b0 : 1'b1;
    end
    chk("press_bounce", bad, 0);
    idle(10);

    // release bounce: raw high for edges 8 and 9 only
    raw = 1'b0; first = -1; nr = 0;
    for (int e = 0; e < 25; e++) begin
      tick();
      if (rpt[0] && first < 0) first = e;
      nr += int'(rp[0]);
      raw = (e + 1 == 8 || e + 1 == 9) ? 1'b1 : 1'b0;
    end
    chk("release_bounce_cadence", first, 18);
    chk("release_bounce_no_release", nr, 0);
    idle(10);

    // reset while held
    raw = 1'b0; first = -1;
    for (int e = 0; e <= 12; e++) tick();
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("midreset_dut%0d", i), 32'(outv(i)), 32'd0);
    #2 reset = 1'b0;
    for (int e = 13; e <= 20; e++) begin
      tick();
      if (pp[0] && first < 0) first = e;
    end
    chk("reset_repress_edge", first, 18);
    idle(10);

    // no auto-repeat configuration
    raw = 1'b0; np = 0; nr = 0; nl = 0;
    for (int e = 0; e < 50; e++) begin
      tick();
      np += int'(pp[1]); nr += int'(rpt[1]); nl |= int'(lp[1]);
    end
    chk("norepeat_press", np, 1);
    chk("norepeat_repeat", nr, 0);
    chk("norepeat_long", nl, 0);
    idle(10);

    // active-high button
    raw_c = 1'b1; first = -1;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (pp[2] && first < 0) first = e;
    end
    chk("active_high_press_edge", first, 5);
    idle(12);

    // random bounce/hold traffic on both raw inputs
    dn_a = 0; dn_c = 0;
    for (int k = 0; k < 3000; k++) begin
      if (dn_a == 0) begin
        raw = ~raw;
        dn_a = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
      end else dn_a--;
      if (dn_c == 0) begin
        raw_c = ~raw_c;
        dn_c = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
      end else dn_c--;
      tick();
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce_repeat.md
BUTTON_DEBOUNCE_REPEAT -- requirements
Module: button_debounce_repeat

Interface
REQ-001 SHALL have parameter STABLE_TICKS, default 4: consecutive equal samples needed to accept a level change; legal range 1..65535.
REQ-002 SHALL have parameter REPEAT_DELAY, default 500: ticks from the press event to the first auto-repeat; 0 disables auto-repeat; legal range 0..65535.
REQ-003 SHALL have parameter REPEAT_RATE, default 100: ticks between later auto-repeats; legal range 1..65535.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 means button_raw=0 is pressed; 0 means button_raw=1 is pressed.
REQ-005 SHALL have port clock_divider_out, input, 1 bit: the slow sample clock; one tick is one rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port button_raw, input, 1 bit: asynchronous pin from the mechanical button.
REQ-008 SHALL have port button_level, output, 1 bit: debounced pressed level.
REQ-009 SHALL have port press_pulse, output, 1 bit: one-cycle pulse on an accepted press.
REQ-010 SHALL have port release_pulse, output, 1 bit: one-cycle pulse on an accepted release.
REQ-011 SHALL have port repeat_pulse, output, 1 bit: one-cycle pulse on each auto-repeat.
REQ-012 SHALL have port count_pulse, output, 1 bit: press_pulse OR repeat_pulse; this is the increment strobe for the downstream counter.
REQ-013 SHALL have port long_press, output, 1 bit: high from the first repeat_pulse until the accepted release.

Function
REQ-014 SHALL pass button_raw through two flops clocked by clock_divider_out, then polarity-correct it to btn_s (1 = pressed).
REQ-015 SHALL implement an FSM with states RELEASED, PRESS_CHECK, PRESSED and RELEASE_CHECK, a 16-bit stable_cnt and a 16-bit repeat_cnt.
REQ-016 SHALL, in RELEASED with btn_s=1, go to PRESS_CHECK with stable_cnt=1; if STABLE_TICKS=1, it SHALL instead accept the press immediately (REQ-018).
REQ-017 SHALL, in PRESS_CHECK with btn_s=0, return to RELEASED with no output pulse; with btn_s=1, stable_cnt SHALL increment.
REQ-018 SHALL accept the press on the edge that takes the STABLE_TICKS-th consecutive pressed sample, with these effects on that edge: state=PRESSED, button_level=1, press_pulse=1 for one cycle, repeat_cnt=0.
REQ-019 SHALL give press_pulse a latency of STABLE_TICKS+1 edges after the first edge that samples the raw press (E0 to E(STABLE_TICKS+1)).
REQ-020 SHALL, in PRESSED with btn_s=1 and REPEAT_DELAY>0, increment repeat_cnt each tick.
REQ-021 SHALL, on reaching the limit, assert repeat_pulse for one cycle, clear repeat_cnt and set long_press=1; the limit SHALL be REPEAT_DELAY-1 before the first repeat and REPEAT_RATE-1 afterwards.
REQ-022 SHALL, in PRESSED with btn_s=0, go to RELEASE_CHECK with stable_cnt=1 and hold repeat_cnt.
REQ-023 SHALL, in RELEASE_CHECK, emit no repeat_pulse.
REQ-024 SHALL, in RELEASE_CHECK with btn_s=1 (bounce), return to PRESSED with no pulse; repeat counting SHALL resume from the held repeat_cnt value.
REQ-025 SHALL accept the release on the STABLE_TICKS-th consecutive released sample, with these effects: state=RELEASED, button_level=0, long_press=0, release_pulse=1 for one cycle, repeat_cnt cleared.
REQ-026 SHALL register all pulses; press_pulse, repeat_pulse and release_pulse are mutually exclusive in any cycle.
REQ-027 SHALL saturate no counter beyond its limit; stable_cnt SHALL never exceed STABLE_TICKS.

Reset
REQ-028 SHALL, while reset=1, asynchronously force: all outputs 0, both sync flops to the released level, state=RELEASED, both counters 0.
REQ-029 SHALL require a full new debounce after reset releases (REQ-019 latency) when the button is held through reset; no pulse SHALL occur during reset.

Verification
REQ-030 Clean press (STABLE_TICKS=4, REPEAT_DELAY=10, REPEAT_RATE=3, ACTIVE_LOW=1): raw low from E0, high from E25 -> press_pulse after E5; repeat_pulse after E15, E18, E21, E24; long_press 1 from E15; release_pulse after E30; count_pulse=5 total.
REQ-031 Press bounce: raw low for samples E0-E1 only -> no pulses, button_level stays 0.
REQ-032 Release bounce: while pressed, raw high 2 ticks then low again -> no release_pulse; repeat cadence delayed by exactly the RELEASE_CHECK ticks spent.
REQ-033 Reset mid-press: reset pulsed at E12 while held -> all outputs 0 immediately; press_pulse again 5 edges after the first post-reset edge.
REQ-034 REPEAT_DELAY=0, hold 50 ticks -> exactly one press_pulse, zero repeat_pulse, long_press stays 0.
REQ-035 ACTIVE_LOW=0, raw high from E0 for 8 ticks -> press_pulse after E5; raw=0 -> no press.
